keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner for arbitrary rows × columns. It integrates per-key debounce and emits press/release events through a valid/ready queue. It replaces the fixed 4×4 scanner, which was followed by a separate level debouncer, and sits between the board keypad pins and any consumer logic. Consumers include the LED mirror, the dot-matrix game logic and the menu FSM. The debounced level vector remains available for simple LED mirroring.

## Interface
- ROWS, 4, keypad row inputs (≥1)
- COLS, 4, keypad column outputs (≥1)
- SCAN_DIV, 50000, settle cycles a column is driven before sampling (≥2)
- DEB_SCANS, 4, consecutive differing samples needed to flip a key state (≥1)
- FIFO_DEPTH, 8, event queue depth (power of 2, ≥2)
- Derived: KW = clog2(ROWS*COLS), key code width

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- kb_row  in  ROWS  row sense lines, active-low: 0 = pressed on the driven column
- kb_col  out  COLS  column drive, one-cold: the scanned column is driven 0, all others 1
- key_state  out  ROWS*COLS  debounced levels; bit `row*COLS+col`, 1 = pressed
- ev_valid  out  1  event queue non-empty
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  KW  head event key index `row*COLS+col`
- ev_press  out  1  head event type: 1 = press, 0 = release
- ev_overflow  out  1  sticky flag, set when an event is dropped
- ev_clr  in  1  clears ev_overflow

## Operation
- kb_row passes through a 2-flop synchroniser before use.
- Scan FSM states:
  - SETTLE: column `col` is driven; a divider counts 0..SCAN_DIV-1. On the terminal count, latch the synchronised rows into `sample`, set r=0 and go to EVAL.
  - EVAL: one row per cycle, r = 0..ROWS-1, for key k = r*COLS+col. After r = ROWS-1 go to NEXT.
  - NEXT: col ← col+1, wrapping from COLS-1 to 0. Clear the divider and go to SETTLE.
- A column takes SCAN_DIV+ROWS+1 cycles; a full scan takes COLS times that.
- Debounce, per key, with a counter of width clog2(DEB_SCANS+1):
  - If sample ≠ key_state[k], increment the counter.
  - If sample = key_state[k], clear the counter.
  - When the increment would reach DEB_SCANS: toggle key_state[k], clear the counter, and push event {k, new state}.
  - DEB_SCANS=1 flips the state on the first differing sample.
- Event queue (FIFO, first in, first out):
  - Push happens in the EVAL cycle that flips a key.
  - Pop happens on ev_valid & ev_ready.
  - If full and a pop occurs in the same cycle, the push succeeds.
  - If full with no pop, the event is dropped, key_state still updates, and ev_overflow is set.
  - When empty, ev_code and ev_press hold their last values, and are 0 after reset.
- ev_overflow: set has priority over ev_clr in the same cycle.
- At most one push per cycle. Simultaneous flips in one column are queued in ascending row order.

## Timing
- Reset values:
  - kb_col = all ones except bit0 = 0 (column 0 driven)
  - key_state = 0, ev_valid = 0, ev_code = 0, ev_press = 0, ev_overflow = 0
  - FSM in SETTLE, col = 0, divider 0, all debounce counters 0, FIFO empty
- Reset mid-scan or with the FIFO non-empty discards everything. There are no spurious release events after reset.
- Pin to sample: 2 synchroniser cycles plus the remaining settle time. A row change in the last 2 settle cycles is seen on the next visit.
- Push to ev_valid: ev_valid is high the cycle after the push (registered FIFO outputs). On pop, the next head is visible the following cycle.
- ev_valid/ev_code/ev_press change only after a pop or a push into an empty queue. They remain stable while ev_valid & !ev_ready.
- Stable press to event: DEB_SCANS full scans at most. The first qualifying sample is within one scan.

## Structure
- Package `keypad_pkg`:
  - constants EV_RELEASE = 1'b0 and EV_PRESS = 1'b1
  - scan FSM state encoding (SETTLE, EVAL, NEXT)
  - key-index/width helper function
- Sub-module `event_fifo`: synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop, full/empty and a registered head.
- Debounce counters and key_state are held in flat per-key arrays in the top module.

## Test plan
All cases use ROWS=4, COLS=4, SCAN_DIV=8, DEB_SCANS=3, FIFO_DEPTH=4.
- Reset → kb_col = 4'b1110, key_state = 0, ev_valid = 0, ev_overflow = 0. kb_col then cycles 1101, 1011, 0111, 1110 at 13-cycle intervals.
- Hold row2 low whenever col1 is driven → exactly one event, code 9, press 1, and key_state[9] = 1. Releasing gives code 9, press 0, and key_state[9] = 0.
- Bounce row2/col1 pressed for 2 consecutive scans, then released → no event, key_state[9] stays 0.
- ev_ready = 0 with 5 distinct key flips → 4 events queued in flip order, and the 5th is dropped with ev_overflow = 1. Draining then gives exactly 4 events. ev_clr clears the flag.
- Keys 1 and 5 (rows 0 and 1 of col1) pressed in the same scan → events with code 1 then code 5 on consecutive pushes, both press 1.
- Assert rst_n low with 3 events queued and key 9 held → ev_valid = 0 and key_state = 0 next cycle. After release of reset, scan restarts at col0 and a press event for 9 re-emerges after 3 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: event polarity, scan FSM
// encoding and index/width helpers.
package keypad_pkg;

    localparam logic EV_RELEASE = 1'b0;
    localparam logic EV_PRESS   = 1'b1;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        EVAL   = 2'd1,
        NEXT   = 2'd2
    } scan_state_e;

    // Index width that never collapses to zero, so single-entry ranges still get a bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int key_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with a registered head word; the head holds its last value
// while the queue is empty.
module event_fifo import keypad_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = head_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The head copy is refreshed only on a push into an empty queue or on a pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && (empty || (do_pop && count_q == (PW+1)'(1)))) begin
            head_d = push_data;
        end else if (do_pop && count_q > (PW+1)'(1)) begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix keypad scanner with per-key debounce and a press/release
// event queue; debounced levels are also exported directly.
module keypad_scanner import keypad_pkg::*; #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 50000,
    parameter  int DEB_SCANS  = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int KW         = idx_width(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      kb_row,
    output logic [COLS-1:0]      kb_col,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [KW-1:0]        ev_code,
    output logic                 ev_press,
    output logic                 ev_overflow,
    input  logic                 ev_clr
);

    localparam int NK  = ROWS * COLS;
    localparam int CW  = idx_width(COLS);
    localparam int RW  = idx_width(ROWS);
    localparam int DW  = idx_width(SCAN_DIV);
    localparam int DCW = $clog2(DEB_SCANS + 1);

    logic [ROWS-1:0] sync1_q, sync2_q;
    scan_state_e     state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   div_q, div_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] sample_q, sample_d;
    logic [NK-1:0]   key_state_q, key_state_d;
    logic [DCW-1:0]  deb_cnt_q [NK];
    logic [DCW-1:0]  deb_cnt_d [NK];
    logic [KW-1:0]   key_idx;
    logic            push;
    logic [KW:0]     push_data;
    logic            fifo_full, fifo_empty;
    logic [KW:0]     fifo_head;
    logic            drop;
    logic            ov_q, ov_d;

    event_fifo #(
        .WIDTH (KW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (ev_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign key_state   = key_state_q;
    assign ev_valid    = !fifo_empty;
    assign ev_code     = fifo_head[KW:1];
    assign ev_press    = fifo_head[0];
    assign ev_overflow = ov_q;
    assign drop        = push && fifo_full && !(ev_ready && !fifo_empty);

    always_comb begin
        kb_col        = '1;
        kb_col[col_q] = 1'b0;
    end

    // Rows are active-low on the pins; samples are stored as 1 = pressed.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        div_d       = div_q;
        row_d       = row_q;
        sample_d    = sample_q;
        key_state_d = key_state_q;
        deb_cnt_d   = deb_cnt_q;
        push        = 1'b0;
        push_data   = '0;
        key_idx     = KW'(key_index(int'(row_q), int'(col_q), COLS));
        case (state_q)
            SETTLE: begin
                if (div_q == DW'(SCAN_DIV - 1)) begin
                    sample_d = ~sync2_q;
                    row_d    = '0;
                    state_d  = EVAL;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            EVAL: begin
                if (sample_q[row_q] != key_state_q[key_idx]) begin
                    if (deb_cnt_q[key_idx] == DCW'(DEB_SCANS - 1)) begin
                        key_state_d[key_idx] = sample_q[row_q];
                        deb_cnt_d[key_idx]   = '0;
                        push                 = 1'b1;
                        push_data            = {key_idx, sample_q[row_q]};
                    end else begin
                        deb_cnt_d[key_idx] = deb_cnt_q[key_idx] + 1'b1;
                    end
                end else begin
                    deb_cnt_d[key_idx] = '0;
                end
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = NEXT;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            NEXT: begin
                col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
                div_d   = '0;
                state_d = SETTLE;
            end
            default: state_d = SETTLE;
        endcase
    end

    // A dropped event wins over a same-cycle clear so the loss is never hidden.
    always_comb begin
        ov_d = ov_q;
        if (ev_clr) begin
            ov_d = 1'b0;
        end
        if (drop) begin
            ov_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            state_q     <= SETTLE;
            col_q       <= '0;
            div_q       <= '0;
            row_q       <= '0;
            sample_q    <= '0;
            key_state_q <= '0;
            ov_q        <= 1'b0;
            for (int i = 0; i < NK; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= kb_row;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            col_q       <= col_d;
            div_q       <= div_d;
            row_q       <= row_d;
            sample_q    <= sample_d;
            key_state_q <= key_state_d;
            ov_q        <= ov_d;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 keypad model driven from kb_col
// and the pressed-key matrix.
module tb_keypad_scanner;

    localparam int SCAN = 52;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  kb_row;
    logic [3:0]  kb_col;
    logic [15:0] key_state;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic        ev_overflow;
    logic        ev_clr = 1'b0;
    logic [15:0] pressed = '0;

    int tests_run = 0;
    int tests_failed = 0;

    keypad_scanner #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (8),
        .DEB_SCANS  (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kb_row      (kb_row),
        .kb_col      (kb_col),
        .key_state   (key_state),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_press    (ev_press),
        .ev_overflow (ev_overflow),
        .ev_clr      (ev_clr)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven.
    always_comb begin
        kb_row = '1;
        for (int c = 0; c < 4; c++) begin
            if (!kb_col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[r*4+c]) kb_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitScanStart();
        logic [3:0] prev;
        prev = kb_col;
        for (int i = 0; i < 2 * SCAN; i++) begin
            stepCycles(1);
            if (kb_col == 4'b1110 && prev != 4'b1110) break;
            prev = kb_col;
        end
    endtask

    task automatic expectEvent(input string tag, input logic [3:0] code, input logic press, input int bound);
        for (int i = 0; i < bound && !ev_valid; i++) stepCycles(1);
        checkOutput({tag, "_valid"}, ev_valid, 1);
        checkOutput({tag, "_code"}, ev_code, code);
        checkOutput({tag, "_press"}, ev_press, press);
        ev_ready = 1'b1;
        stepCycles(1);
        ev_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] col_seq [4];
        col_seq[0] = 4'b1101;
        col_seq[1] = 4'b1011;
        col_seq[2] = 4'b0111;
        col_seq[3] = 4'b1110;

        stepCycles(2);
        checkOutput("rst_kb_col", kb_col, 4'b1110);
        checkOutput("rst_key_state", key_state, 16'h0000);
        checkOutput("rst_ev_valid", ev_valid, 0);
        checkOutput("rst_ev_code", ev_code, 0);
        checkOutput("rst_ev_press", ev_press, 0);
        checkOutput("rst_ev_overflow", ev_overflow, 0);
        rst_n = 1'b1;

        stepCycles(12);
        checkOutput("col0_hold", kb_col, 4'b1110);
        stepCycles(1);
        checkOutput("col_step0", kb_col, col_seq[0]);
        for (int i = 1; i < 4; i++) begin
            stepCycles(13);
            checkOutput($sformatf("col_step%0d", i), kb_col, col_seq[i]);
        end

        applyStimulus(16'h0200);
        expectEvent("press9", 4'd9, 1'b1, 3 * SCAN + 4);
        checkOutput("press9_level", key_state[9], 1);
        checkOutput("press9_popped", ev_valid, 0);
        stepCycles(2 * SCAN);
        checkOutput("press9_single", ev_valid, 0);
        applyStimulus(16'h0000);
        expectEvent("release9", 4'd9, 1'b0, 4 * SCAN);
        checkOutput("release9_level", key_state[9], 0);

        waitScanStart();
        applyStimulus(16'h0200);
        stepCycles(2 * SCAN);
        applyStimulus(16'h0000);
        stepCycles(3 * SCAN);
        checkOutput("bounce_no_event", ev_valid, 0);
        checkOutput("bounce_level", key_state[9], 0);

        waitScanStart();
        applyStimulus(16'h8431);
        stepCycles(3 * SCAN + 8);
        checkOutput("ovf_flag", ev_overflow, 1);
        checkOutput("ovf_levels", key_state, 16'h8431);
        expectEvent("ovf_ev0", 4'd0, 1'b1, 4);
        expectEvent("ovf_ev1", 4'd4, 1'b1, 4);
        expectEvent("ovf_ev2", 4'd5, 1'b1, 4);
        expectEvent("ovf_ev3", 4'd10, 1'b1, 4);
        checkOutput("ovf_drained", ev_valid, 0);
        checkOutput("ovf_sticky", ev_overflow, 1);
        ev_clr = 1'b1;
        stepCycles(1);
        ev_clr = 1'b0;
        checkOutput("ovf_cleared", ev_overflow, 0);
        waitScanStart();
        applyStimulus(16'h0000);
        expectEvent("rel_ev0", 4'd0, 1'b0, 4 * SCAN);
        expectEvent("rel_ev1", 4'd4, 1'b0, SCAN);
        expectEvent("rel_ev2", 4'd5, 1'b0, SCAN);
        expectEvent("rel_ev3", 4'd10, 1'b0, SCAN);
        expectEvent("rel_ev4", 4'd15, 1'b0, SCAN);
        checkOutput("rel_levels", key_state, 16'h0000);

        applyStimulus(16'h0022);
        expectEvent("pair_first", 4'd1, 1'b1, 4 * SCAN);
        expectEvent("pair_second", 4'd5, 1'b1, 2);
        applyStimulus(16'h0000);
        expectEvent("pair_rel_first", 4'd1, 1'b0, 4 * SCAN);
        expectEvent("pair_rel_second", 4'd5, 1'b0, 2);

        waitScanStart();
        applyStimulus(16'h020C);
        stepCycles(3 * SCAN + 8);
        checkOutput("pre_rst_valid", ev_valid, 1);
        checkOutput("pre_rst_levels", key_state, 16'h020C);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", ev_valid, 0);
        checkOutput("mid_rst_levels", key_state, 16'h0000);
        checkOutput("mid_rst_kb_col", kb_col, 4'b1110);
        applyStimulus(16'h0200);
        stepCycles(2);
        rst_n = 1'b1;
        stepCycles(1);
        checkOutput("post_rst_kb_col", kb_col, 4'b1110);
        stepCycles(2 * SCAN - 1);
        checkOutput("post_rst_no_early", ev_valid, 0);
        expectEvent("post_rst_press9", 4'd9, 1'b1, SCAN + 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
